stack_controller: RTL and testbench
===================================

// Module: stack_controller
// PURPOSE
//  Sequences the operand-stack RAM on behalf of the control unit.
//  Converts one-cycle op requests (PUSH/POP/PEEK/REPLACE) into address/wren strobes for a
//  single-port, synchronous-read stack RAM.
//  Owns the stack pointer, full/empty flags and sticky overflow/underflow errors.
//  Sits between the control-unit FSM and the stack memory. The arithmetic result path
//  uses REPLACE to overwrite top-of-stack.
// PARAMETERS
//  DATA_W   8  stack word width
//  ADDR_W   4  stack RAM address width; DEPTH = 2**ADDR_W entries
// PORTS
//  clock      in   1         single clock, rising edge
//  reset      in   1         asynchronous, active-high; clears all state
//  op_valid   in   1         request strobe; accepted when op_valid & op_ready
//  op         in   2         00 PUSH, 01 POP, 10 PEEK, 11 REPLACE
//  wr_data    in   DATA_W    operand for PUSH/REPLACE; sampled at accept
//  op_ready   out  1         high only in IDLE
//  op_done    out  1         one-cycle pulse when the op retires (incl. error-retire)
//  op_err     out  1         valid with op_done; 1 = op rejected (overflow/underflow)
//  rd_data    out  DATA_W    popped/peeked word; holds until the next POP/PEEK retires
//  sp         out  ADDR_W+1  occupancy, 0..DEPTH
//  full       out  1         sp == DEPTH
//  empty      out  1         sp == 0
//  ovf        out  1         sticky: PUSH attempted while full
//  udf        out  1         sticky: POP/PEEK/REPLACE attempted while empty
//  err_clr    in   1         clears ovf/udf; a same-cycle new error wins (flag stays 1)
//  mem_addr   out  ADDR_W    stack RAM address
//  mem_wdata  out  DATA_W    stack RAM write data
//  mem_wren   out  1         stack RAM write enable
//  mem_rdata  in   DATA_W    RAM read data, valid the cycle after mem_addr is presented
// BEHAVIOUR
//  Reset values: state=IDLE, sp=0, rd_data=0, op_done=0, op_err=0, ovf=0, udf=0,
//   mem_wren=0, mem_addr=0, mem_wdata=0.
//  Reset mid-operation aborts it: no write is issued and no op_done pulse occurs.
//  FSM states: IDLE, RD_ADDR, RD_DATA, WR, DONE.
//  IDLE: op_ready=1. On accept, latch op and wr_data, then:
//   - PUSH & full                  -> DONE, op_err=1, set ovf; sp unchanged.
//   - POP/PEEK/REPLACE & empty     -> DONE, op_err=1, set udf; sp unchanged.
//   - PUSH                         -> WR: addr=sp[ADDR_W-1:0], wren=1; sp<=sp+1 at WR exit.
//   - REPLACE                      -> WR: addr=sp-1, wren=1; sp unchanged.
//   - POP/PEEK                     -> RD_ADDR: addr=sp-1, wren=0.
//  RD_ADDR -> RD_DATA.
//  RD_DATA: rd_data<=mem_rdata; POP also does sp<=sp-1; -> DONE.
//  WR -> DONE.
//  DONE: op_done=1 (registered pulse), op_err as decided; -> IDLE.
//  Latency from accept edge to op_done: PUSH/REPLACE 2 cycles, POP/PEEK 3 cycles,
//   error 1 cycle. Throughput is one op in flight.
//  op_valid while op_ready=0 is ignored; the requester must hold op_valid until accepted.
//  mem_wren is asserted only in WR, so no write is ever issued on a rejected op.
//  sp never wraps: it saturates logically via the full/empty checks.
//  full/empty are decoded combinationally from registered sp.
//  Illegal FSM state -> IDLE.
// STRUCTURE
//  stack_pkg: op encodings (OP_PUSH..OP_REPLACE) and FSM state localparams.
//  One sub-module is natural: stack_ptr. It holds the up/down occupancy counter plus the
//   full/empty decode.
//  FSM, data latches and error flags stay in stack_controller.
//  Bench uses a behavioural 1-cycle-latency RAM model.
// TESTING
//  1. reset; PUSH 0x11, PUSH 0x22
//     -> mem writes addr0=0x11, addr1=0x22; sp=2; each op_done 2 cycles after accept.
//  2. From test 1, POP
//     -> mem_addr=1 in RD_ADDR; rd_data=0x22, sp=1; op_done 3 cycles after accept.
//  3. PEEK with sp=1
//     -> rd_data=0x11, sp stays 1; REPLACE 0x5A then PEEK -> rd_data=0x5A, sp=1.
//  4. DEPTH=16: 16 PUSHes -> full=1; 17th PUSH
//     -> op_done&op_err, ovf=1, no mem_wren, sp=16.
//  5. Empty stack: POP -> udf=1, op_err=1.
//     Then err_clr together with a new POP on an empty stack -> udf stays 1.
//     err_clr alone -> udf=0.
//  6. Assert reset during RD_DATA of a POP
//     -> sp=0, no op_done; after release op_ready=1 and the next PUSH writes addr0.

Source files
------------

// File: rtl/stack_controller_pkg.sv
// Shared types for the operand-stack controller: op encodings and FSM states.
package stack_controller_pkg;

  typedef enum logic [1:0] {
    OP_PUSH    = 2'b00,
    OP_POP     = 2'b01,
    OP_PEEK    = 2'b10,
    OP_REPLACE = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR      = 3'd3,
    S_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/stack_controller_if.sv
// Op request/response handshake between the control-unit FSM and the stack controller.
interface stack_controller_if #(parameter int DATA_W = 8);
  import stack_controller_pkg::*;

  logic              op_valid;
  op_t               op;
  logic [DATA_W-1:0] wr_data;
  logic              err_clr;
  logic              op_ready;
  logic              op_done;
  logic              op_err;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output op_valid, op, wr_data, err_clr,
    input  op_ready, op_done, op_err, rd_data
  );

  modport slave (
    input  op_valid, op, wr_data, err_clr,
    output op_ready, op_done, op_err, rd_data
  );

endinterface

// File: rtl/stack_controller_ptr.sv
// Stack occupancy counter (0..DEPTH) with combinational full/empty decode.
module stack_ptr #(
  parameter int ADDR_W = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            inc,
  input  logic            dec,
  output logic [ADDR_W:0] sp,
  output logic            full,
  output logic            empty
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  // Guards keep the count inside 0..DEPTH even if a caller misbehaves.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp <= '0;
    end else if (inc && !dec && !full) begin
      sp <= sp + ONE;
    end else if (dec && !inc && !empty) begin
      sp <= sp - ONE;
    end
  end

  assign full  = (sp == DEPTH);
  assign empty = (sp == '0);

endmodule

// File: rtl/stack_controller.sv
// Sequences a single-port synchronous-read stack RAM for PUSH/POP/PEEK/REPLACE requests,
// owning the stack pointer and the sticky overflow/underflow flags.
module stack_controller
  import stack_controller_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  stack_controller_if.slave   bus,
  output logic [ADDR_W:0]     sp,
  output logic                full,
  output logic                empty,
  output logic                ovf,
  output logic                udf,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_wren,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_next;
  op_t               op_q;
  logic              accept;
  logic              ovf_set;
  logic              udf_set;
  logic              sp_inc;
  logic              sp_dec;
  logic [ADDR_W-1:0] top_addr;

  assign accept   = (state == S_IDLE) && bus.op_valid;
  assign top_addr = sp[ADDR_W-1:0] - ONE_A;
  assign sp_inc   = (state == S_WR) && (op_q == OP_PUSH);
  assign sp_dec   = (state == S_RD_DATA) && (op_q == OP_POP);

  assign bus.op_ready = (state == S_IDLE);
  assign mem_wren     = (state == S_WR);

  stack_ptr #(.ADDR_W(ADDR_W)) u_ptr (
    .clock (clock),
    .reset (reset),
    .inc   (sp_inc),
    .dec   (sp_dec),
    .sp    (sp),
    .full  (full),
    .empty (empty)
  );

  // Rejected ops go straight to DONE so they never reach the write state.
  always_comb begin
    state_next = state;
    ovf_set    = 1'b0;
    udf_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.op_valid) begin
          if (bus.op == OP_PUSH && full) begin
            ovf_set    = 1'b1;
            state_next = S_DONE;
          end else if (bus.op != OP_PUSH && empty) begin
            udf_set    = 1'b1;
            state_next = S_DONE;
          end else if (bus.op == OP_PUSH || bus.op == OP_REPLACE) begin
            state_next = S_WR;
          end else begin
            state_next = S_RD_ADDR;
          end
        end
      end
      S_RD_ADDR: state_next = S_RD_DATA;
      S_RD_DATA: state_next = S_DONE;
      S_WR:      state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      op_q        <= OP_PUSH;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      bus.rd_data <= '0;
      bus.op_done <= 1'b0;
      bus.op_err  <= 1'b0;
      ovf         <= 1'b0;
      udf         <= 1'b0;
    end else begin
      state       <= state_next;
      bus.op_done <= (state_next == S_DONE);
      bus.op_err  <= ovf_set | udf_set;
      if (accept) begin
        op_q      <= bus.op;
        mem_wdata <= bus.wr_data;
        mem_addr  <= (bus.op == OP_PUSH) ? sp[ADDR_W-1:0] : top_addr;
      end
      if (state == S_RD_DATA) begin
        bus.rd_data <= mem_rdata;
      end
      // A new error in the same cycle as err_clr keeps the flag set.
      ovf <= ovf_set | (ovf & ~bus.err_clr);
      udf <= udf_set | (udf & ~bus.err_clr);
    end
  end

endmodule

// File: tb/tb_stack_controller.sv
// Scoreboard bench for stack_controller with a 1-cycle-latency behavioural stack RAM.
module tb_stack_controller;
  import stack_controller_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] sp;
  logic       full, empty, ovf, udf;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_wren;
  logic [7:0] mem_rdata;

  stack_controller_if #(.DATA_W(8)) bus ();

  stack_controller #(.DATA_W(8), .ADDR_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .sp        (sp),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf),
    .udf       (udf),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wren  (mem_wren),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  logic [7:0] ram [16];
  int         wr_count = 0;
  logic [3:0] last_wr_addr = '0;
  logic [7:0] last_wr_data = '0;

  always @(posedge clock) begin
    if (mem_wren) begin
      ram[mem_addr] <= mem_wdata;
      wr_count      = wr_count + 1;
      last_wr_addr  = mem_addr;
      last_wr_data  = mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    op_t        op;
    logic [7:0] d;
    logic       clr;
    logic       err;
    int         lat;
    logic       chk_rd;
    logic [7:0] rd;
    logic       chk_a;
    logic [3:0] a1;
    int         nwr;
    logic [3:0] wa;
    logic [7:0] wd;
    logic [4:0] sp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic       ge;
  logic [7:0] gr;
  int         gl;
  logic [3:0] ga;
  logic       gt;
  int         wc0;
  exp_t       e;

  function automatic exp_t mk(op_t op, logic [7:0] d, logic clr, logic err, int lat,
                              logic chk_rd, logic [7:0] rd, logic chk_a, logic [3:0] a1,
                              int nwr, logic [3:0] wa, logic [7:0] wd, logic [4:0] spv);
    exp_t r;
    r.op = op; r.d = d; r.clr = clr; r.err = err; r.lat = lat;
    r.chk_rd = chk_rd; r.rd = rd; r.chk_a = chk_a; r.a1 = a1;
    r.nwr = nwr; r.wa = wa; r.wd = wd; r.sp = spv;
    return r;
  endfunction

  task automatic apply_reset();
    bus.op_valid = 1'b0;
    bus.err_clr  = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Drives one request, waits for accept and then op_done; observations only.
  task automatic run_op(input op_t o, input logic [7:0] d, input logic clr,
                        output logic got_err, output logic [7:0] got_rd, output int lat,
                        output logic [3:0] addr1, output logic to);
    int n;
    to = 1'b0; lat = 0; got_err = 1'b0; got_rd = '0; addr1 = '0;
    @(negedge clock);
    bus.op_valid = 1'b1; bus.op = o; bus.wr_data = d; bus.err_clr = clr;
    n = 0;
    while (!bus.op_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!bus.op_ready) begin
      to = 1'b1; bus.op_valid = 1'b0; bus.err_clr = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    bus.op_valid = 1'b0; bus.err_clr = 1'b0;
    lat = 1; addr1 = mem_addr;
    while (!bus.op_done && lat < 10) begin
      @(posedge clock);
      #1;
      lat++;
    end
    if (!bus.op_done) to = 1'b1;
    got_err = bus.op_err;
    got_rd  = bus.rd_data;
  endtask

  task automatic test_reset();
    bus.op_valid = 1'b0; bus.op = OP_PUSH; bus.wr_data = '0; bus.err_clr = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total++;
    if ({sp, full, empty, ovf, udf} !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_flags: got sp=%0d f=%b e=%b o=%b u=%b want sp=0 f=0 e=1 o=0 u=0",
                      sp, full, empty, ovf, udf);
    end
    total++;
    if ({bus.op_ready, bus.op_done, bus.op_err} !== 3'b100) begin
      bad++; $display("FAIL reset_hs: got rdy=%b done=%b err=%b want 1 0 0",
                      bus.op_ready, bus.op_done, bus.op_err);
    end
    total++;
    if ({bus.rd_data, mem_wren, mem_addr, mem_wdata} !== 21'd0) begin
      bad++; $display("FAIL reset_data: got rd=%h wren=%b addr=%h wdata=%h want all 0",
                      bus.rd_data, mem_wren, mem_addr, mem_wdata);
    end
  endtask

  task automatic check_list(input string tag, input exp_t tbl[$]);
    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      wc0 = wr_count;
      run_op(tbl[i].op, tbl[i].d, tbl[i].clr, ge, gr, gl, ga, gt);
      e = sb.pop_front();
      total++;
      if (gt || ge !== e.err || gl != e.lat || (e.chk_rd && gr !== e.rd) ||
          (e.chk_a && ga !== e.a1) || (wr_count - wc0) != e.nwr ||
          (e.nwr > 0 && (last_wr_addr !== e.wa || last_wr_data !== e.wd)) || sp !== e.sp) begin
        bad++;
        $display("FAIL %s[%0d]: got to=%b err=%b lat=%0d rd=%h a1=%h wr=%0d@%h:%h sp=%0d want err=%b lat=%0d rd=%h a1=%h wr=%0d@%h:%h sp=%0d",
                 tag, i, gt, ge, gl, gr, ga, wr_count - wc0, last_wr_addr, last_wr_data, sp,
                 e.err, e.lat, e.rd, e.a1, e.nwr, e.wa, e.wd, e.sp);
      end
    end
  endtask

  task automatic test_push();
    exp_t t[$];
    t.push_back(mk(OP_PUSH, 8'h11, 0, 0, 2, 0, 0, 1, 4'd0, 1, 4'd0, 8'h11, 5'd1));
    t.push_back(mk(OP_PUSH, 8'h22, 0, 0, 2, 0, 0, 1, 4'd1, 1, 4'd1, 8'h22, 5'd2));
    check_list("push", t);
  endtask

  task automatic test_pop();
    exp_t t[$];
    t.push_back(mk(OP_POP, 8'h00, 0, 0, 3, 1, 8'h22, 1, 4'd1, 0, 4'd0, 8'h00, 5'd1));
    check_list("pop", t);
  endtask

  task automatic test_peek_replace();
    exp_t t[$];
    t.push_back(mk(OP_PEEK,    8'h00, 0, 0, 3, 1, 8'h11, 1, 4'd0, 0, 4'd0, 8'h00, 5'd1));
    t.push_back(mk(OP_REPLACE, 8'h5A, 0, 0, 2, 0, 8'h00, 1, 4'd0, 1, 4'd0, 8'h5A, 5'd1));
    t.push_back(mk(OP_PEEK,    8'h00, 0, 0, 3, 1, 8'h5A, 1, 4'd0, 0, 4'd0, 8'h00, 5'd1));
    check_list("peek_replace", t);
  endtask

  task automatic test_overflow();
    exp_t t[$];
    exp_t u[$];
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      t.push_back(mk(OP_PUSH, 8'h30 + 8'(i), 0, 0, 2, 0, 0, 1, 4'(i), 1, 4'(i),
                     8'h30 + 8'(i), 5'(i + 1)));
    end
    check_list("fill", t);
    total++;
    if (full !== 1'b1 || empty !== 1'b0 || ovf !== 1'b0) begin
      bad++; $display("FAIL full_flag: got full=%b empty=%b ovf=%b want 1 0 0", full, empty, ovf);
    end
    u.push_back(mk(OP_PUSH, 8'hEE, 0, 1, 1, 0, 0, 0, 4'd0, 0, 4'd0, 8'h00, 5'd16));
    u.push_back(mk(OP_POP,  8'h00, 0, 0, 3, 1, 8'h3F, 1, 4'd15, 0, 4'd0, 8'h00, 5'd15));
    check_list("ovf", u);
    total++;
    if (ovf !== 1'b1 || udf !== 1'b0 || full !== 1'b0) begin
      bad++; $display("FAIL ovf_sticky: got ovf=%b udf=%b full=%b want 1 0 0", ovf, udf, full);
    end
  endtask

  task automatic test_underflow();
    exp_t t[$];
    exp_t u[$];
    apply_reset();
    t.push_back(mk(OP_POP,     8'h00, 0, 1, 1, 0, 0, 0, 4'd0, 0, 4'd0, 8'h00, 5'd0));
    t.push_back(mk(OP_REPLACE, 8'h44, 0, 1, 1, 0, 0, 0, 4'd0, 0, 4'd0, 8'h00, 5'd0));
    check_list("udf", t);
    total++;
    if (udf !== 1'b1 || ovf !== 1'b0) begin
      bad++; $display("FAIL udf_set: got udf=%b ovf=%b want 1 0", udf, ovf);
    end
    u.push_back(mk(OP_POP, 8'h00, 1, 1, 1, 0, 0, 0, 4'd0, 0, 4'd0, 8'h00, 5'd0));
    check_list("udf_clr_race", u);
    total++;
    if (udf !== 1'b1) begin
      bad++; $display("FAIL udf_clr_race_flag: got udf=%b want 1", udf);
    end
    @(negedge clock);
    bus.err_clr = 1'b1;
    @(negedge clock);
    bus.err_clr = 1'b0;
    total++;
    if (udf !== 1'b0 || ovf !== 1'b0) begin
      bad++; $display("FAIL err_clr: got udf=%b ovf=%b want 0 0", udf, ovf);
    end
  endtask

  task automatic test_reset_abort();
    exp_t t[$];
    exp_t u[$];
    int   dn;
    t.push_back(mk(OP_PUSH, 8'h77, 0, 0, 2, 0, 0, 1, 4'd0, 1, 4'd0, 8'h77, 5'd1));
    check_list("abort_setup", t);
    @(negedge clock);
    bus.op_valid = 1'b1; bus.op = OP_POP;
    @(posedge clock);
    #1;
    bus.op_valid = 1'b0;
    @(posedge clock);
    #1;
    wc0 = wr_count;
    reset = 1'b1;
    dn = 0;
    repeat (2) begin
      @(negedge clock);
      if (bus.op_done) dn++;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (bus.op_done) dn++;
    end
    total++;
    if (dn != 0 || sp !== 5'd0 || bus.op_ready !== 1'b1 || wr_count != wc0) begin
      bad++; $display("FAIL reset_abort: got done_pulses=%0d sp=%0d rdy=%b writes=%0d want 0 0 1 0",
                      dn, sp, bus.op_ready, wr_count - wc0);
    end
    u.push_back(mk(OP_PUSH, 8'h99, 0, 0, 2, 0, 0, 1, 4'd0, 1, 4'd0, 8'h99, 5'd1));
    check_list("after_abort", u);
  endtask

  initial begin
    test_reset();
    test_push();
    test_pop();
    test_peek_replace();
    test_overflow();
    test_underflow();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
